// File: rtl/rv_regfile_sb_pkg.sv
// Shared definitions for the scoreboarded register file.
// Holds the controller state enum and the default geometry constants
// used by the top level and the read-port sub-module.
package rv_regfile_sb_pkg;

  // INIT walks the register array clearing it, RUN is normal operation.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;
  localparam int NRP_DEFAULT  = 2;

endpackage : rv_regfile_sb_pkg

// File: rtl/rv_regfile_rdport.sv
// One combinational read port of the scoreboarded register file.
// Ports:
//   run          in   controller is in RUN (outputs forced to zero otherwise)
//   addr         in   register address for this port
//   stored_data  in   stored value of the addressed register (0 for x0)
//   stored_busy  in   stored busy bit of the addressed register
//   wr_en        in   writeback strobe of the current cycle
//   wr_addr      in   writeback register of the current cycle
//   wr_data      in   writeback data of the current cycle
//   data         out  read data
//   busy         out  scoreboard busy flag
module rv_regfile_rdport
  import rv_regfile_sb_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int AW   = $clog2(NREG_DEFAULT)
) (
  input  logic            run,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] stored_data,
  input  logic            stored_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] data,
  output logic            busy
);

  // x0 and the INIT phase always read as zero / not busy. A writeback
  // to the same register in this cycle is forwarded so a waiting
  // consumer sees the value (and a cleared busy) without an extra cycle.
  always_comb begin
    data = '0;
    busy = 1'b0;
    if (run && (addr != '0)) begin
      if (wr_en && (wr_addr == addr)) begin
        data = wr_data;
        busy = 1'b0;
      end else begin
        data = stored_data;
        busy = stored_busy;
      end
    end
  end

endmodule : rv_regfile_rdport

// File: rtl/rv_regfile_sb.sv
// Register file with a per-register scoreboard busy bit.
// After reset an INIT sequence clears registers 1..NREG-1, one per cycle,
// then ready rises. In RUN, resv_en marks a destination busy at issue time
// and wr_en writes the result back and clears the busy bit.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   rs_addr      NRP packed read addresses (port i = slice i)
//   rs_data      NRP packed read data, combinational
//   rs_busy      per-port busy flag, combinational
//   resv_en/addr reserve a destination register
//   wr_en/addr/data  writeback
//   ready        high once the INIT sequence has completed
module rv_regfile_sb
  import rv_regfile_sb_pkg::*;
#(
  parameter  int XLEN = XLEN_DEFAULT,
  parameter  int NREG = NREG_DEFAULT,
  parameter  int NRP  = NRP_DEFAULT,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRP*AW-1:0]   rs_addr,
  output logic [NRP*XLEN-1:0] rs_data,
  output logic [NRP-1:0]      rs_busy,
  input  logic                resv_en,
  input  logic [AW-1:0]       resv_addr,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  output logic                ready
);

  state_t          state;
  logic [AW-1:0]   init_cnt;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [XLEN-1:0] regs [1:NREG-1];
  logic            run;

  assign run = (state == RUN);

  // Controller: the init counter starts at 1 (x0 is not stored) and stops
  // at NREG-1 without wrapping; ready is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= AW'(1);
      ready    <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (init_cnt == AW'(NREG - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
          ready <= 1'b1;
        end
        default: begin
          state <= INIT;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Writeback clears, reservation sets; applying the set last lets a
  // same-cycle reservation (the newer producer) win over the writeback.
  always_comb begin
    busy_nxt = busy;
    if (run) begin
      if (wr_en && (wr_addr != '0)) begin
        busy_nxt[wr_addr] = 1'b0;
      end
      if (resv_en && (resv_addr != '0)) begin
        busy_nxt[resv_addr] = 1'b1;
      end
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Data storage has no reset; INIT zeroes it before anything can read it.
  always_ff @(posedge clk) begin
    if (!run) begin
      if (init_cnt != '0) begin
        regs[init_cnt] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rdport
    logic [AW-1:0]   port_addr;
    logic [XLEN-1:0] port_stored;

    assign port_addr   = rs_addr[p*AW +: AW];
    assign port_stored = (port_addr == '0) ? '0 : regs[port_addr];

    rv_regfile_rdport #(
      .XLEN(XLEN),
      .AW  (AW)
    ) u_rdport (
      .run        (run),
      .addr       (port_addr),
      .stored_data(port_stored),
      .stored_busy(busy[port_addr]),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .data       (rs_data[p*XLEN +: XLEN]),
      .busy       (rs_busy[p])
    );
  end

endmodule : rv_regfile_sb

// File: tb/tb_rv_regfile_sb.sv
// Randomised self-checking bench for rv_regfile_sb (XLEN=32, NREG=32, NRP=2)
// against a behavioural model: an array of register values, an array of
// busy flags and a count of remaining INIT cycles.
module tb_rv_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRP*AW-1:0]   rs_addr;
  logic [NRP*XLEN-1:0] rs_data;
  logic [NRP-1:0]      rs_busy;
  logic                resv_en;
  logic [AW-1:0]       resv_addr;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                ready;

  logic [XLEN-1:0] m_val [NREG];
  bit              m_busy [NREG];
  int              m_init_left;

  int n_vec = 0;
  int n_err = 0;

  rv_regfile_sb #(
    .XLEN(XLEN),
    .NREG(NREG),
    .NRP (NRP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs_addr  (rs_addr),
    .rs_data  (rs_data),
    .rs_busy  (rs_busy),
    .resv_en  (resv_en),
    .resv_addr(resv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int r = 0; r < NREG; r++) begin
      m_val[r]  = '0;
      m_busy[r] = 1'b0;
    end
    m_init_left = NREG - 1;
  endtask

  // Compare both read ports and ready against the model for the inputs
  // currently driven.
  task automatic checkPorts(input string tag);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] ed;
    bit              eb;
    bit              in_run;
    in_run = rst_n && (m_init_left == 0);
    for (int p = 0; p < NRP; p++) begin
      a  = rs_addr[p*AW +: AW];
      ed = '0;
      eb = 1'b0;
      if (in_run && a != 0) begin
        if (wr_en && wr_addr == a) begin
          ed = wr_data;
        end else begin
          ed = m_val[a];
          eb = m_busy[a];
        end
      end
      checkOutput($sformatf("%s_p%0d_x%0d_data", tag, p, a), rs_data[p*XLEN +: XLEN], ed);
      checkOutput($sformatf("%s_p%0d_x%0d_busy", tag, p, a), 32'(rs_busy[p]), 32'(eb));
    end
    checkOutput($sformatf("%s_ready", tag), 32'(ready), 32'(in_run));
  endtask

  // One cycle: drive inputs after the falling edge, check the combinational
  // outputs, then advance the model across the rising edge.
  task automatic applyStimulus(input string tag, input bit re, input int ra,
                               input bit we, input int wa, input logic [31:0] wd,
                               input int a0, input int a1);
    @(negedge clk);
    resv_en   = re;
    resv_addr = AW'(ra);
    wr_en     = we;
    wr_addr   = AW'(wa);
    wr_data   = wd;
    rs_addr   = {AW'(a1), AW'(a0)};
    #1;
    checkPorts(tag);
    @(posedge clk);
    if (m_init_left > 0) begin
      m_init_left--;
    end else begin
      if (we && wa != 0) begin
        m_val[wa]  = wd;
        m_busy[wa] = 1'b0;
      end
      if (re && ra != 0) begin
        m_busy[ra] = 1'b1;
      end
    end
  endtask

  task automatic applyRandom(input string tag);
    applyStimulus(tag, bit'($urandom_range(0, 2) == 0), $urandom_range(0, 11),
                  bit'($urandom_range(0, 1)), $urandom_range(0, 11), $urandom(),
                  $urandom_range(0, 11), $urandom_range(0, 31));
  endtask

  // Pulse reset mid-operation and check the outputs fall immediately.
  task automatic pulseReset(input int a0, input int a1);
    @(negedge clk);
    rs_addr = {AW'(a1), AW'(a0)};
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkPorts("in_reset");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    resv_en   = 1'b0;
    resv_addr = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rs_addr   = {AW'(5), AW'(1)};
    modelReset();
    #3;
    checkPorts("por");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // INIT with random traffic, which must be ignored; then check x1..x31.
    for (int i = 0; i < NREG - 1; i++) applyRandom("init");
    for (int r = 0; r < NREG; r += 2) applyStimulus("cleared", 0, 0, 0, 0, 0, r, r + 1);

    applyStimulus("wr_x5_bypass", 0, 0, 1, 5, 32'hDEADBEEF, 5, 5);
    applyStimulus("rd_x5", 0, 0, 0, 0, 0, 5, 5);

    applyStimulus("resv_x7", 1, 7, 0, 0, 0, 7, 7);
    applyStimulus("rd_x7_busy", 0, 0, 0, 0, 0, 7, 7);
    applyStimulus("wr_x7_bypass", 0, 0, 1, 7, 32'h12, 7, 7);
    applyStimulus("rd_x7", 0, 0, 0, 0, 0, 7, 7);

    applyStimulus("resv_wr_x9", 1, 9, 1, 9, 32'hCAFE0009, 9, 9);
    applyStimulus("rd_x9", 0, 0, 0, 0, 0, 9, 9);

    applyStimulus("x0_wr_resv", 1, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
    applyStimulus("rd_x0", 0, 0, 0, 0, 0, 0, 5);

    applyStimulus("wr_idle_x4", 0, 0, 1, 4, 32'h0BADF00D, 4, 5);
    applyStimulus("rd_x4", 0, 0, 0, 0, 0, 4, 9);

    applyStimulus("resv_x3", 1, 3, 0, 0, 0, 3, 3);
    applyStimulus("rd_x3_busy", 0, 0, 0, 0, 0, 3, 5);
    pulseReset(3, 5);
    for (int i = 0; i < NREG - 1; i++) applyStimulus("reinit", 0, 0, 0, 0, 0, 3, 5);
    applyStimulus("rd_x3_after", 0, 0, 0, 0, 0, 3, 7);

    for (int i = 0; i < 400; i++) begin
      if (i == 250) begin
        pulseReset($urandom_range(0, 11), $urandom_range(0, 11));
      end
      applyRandom("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_rv_regfile_sb
